// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer: walks (i, j, k) tile triples over a TILE x TILE systolic core,
// generating per-tile A/B/C addresses incrementally and handshaking with the core.
module matmul_tile_sequencer #(
  parameter int AWIDTH = 10,
  parameter int TILE   = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  m_tiles,
  input  logic [CNT_W-1:0]  n_tiles,
  input  logic [CNT_W-1:0]  k_tiles,
  input  logic [AWIDTH-1:0] base_a,
  input  logic [AWIDTH-1:0] base_b,
  input  logic [AWIDTH-1:0] base_c,
  input  logic [AWIDTH-1:0] row_step_a,
  input  logic [AWIDTH-1:0] row_step_b,
  input  logic [AWIDTH-1:0] row_step_c,
  output logic              core_start,
  input  logic              core_done,
  output logic              core_pe_reset,
  output logic [AWIDTH-1:0] core_addr_a,
  output logic [AWIDTH-1:0] core_addr_b,
  output logic [AWIDTH-1:0] core_addr_c,
  output logic              c_commit,
  output logic [CNT_W-1:0]  tile_i,
  output logic [CNT_W-1:0]  tile_j,
  output logic [CNT_W-1:0]  tile_k,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_DRAIN,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic [AWIDTH-1:0] TILE_STEP = AWIDTH'(TILE);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state_reg;

  // Captured configuration; counts are held as "last index" values.
  logic [CNT_W-1:0]  m_last_reg;
  logic [CNT_W-1:0]  n_last_reg;
  logic [CNT_W-1:0]  k_last_reg;
  logic [AWIDTH-1:0] step_a_reg;
  logic [AWIDTH-1:0] step_b_reg;
  logic [AWIDTH-1:0] step_c_reg;
  logic [AWIDTH-1:0] base_b_reg;

  logic [CNT_W-1:0]  i_reg;
  logic [CNT_W-1:0]  j_reg;
  logic [CNT_W-1:0]  k_reg;

  // Row/column anchors let each loop level restart its inner address without multiplying.
  logic [AWIDTH-1:0] row_a_reg;
  logic [AWIDTH-1:0] col_b_reg;
  logic [AWIDTH-1:0] row_c_reg;
  logic [AWIDTH-1:0] addr_a_reg;
  logic [AWIDTH-1:0] addr_b_reg;
  logic [AWIDTH-1:0] addr_c_reg;

  logic              core_start_reg;
  logic              core_pe_reset_reg;
  logic              c_commit_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic              k_at_last;
  logic              j_at_last;
  logic              i_at_last;
  logic              any_zero;
  logic [CNT_W-1:0]  k_next;
  logic [AWIDTH-1:0] row_a_next;
  logic [AWIDTH-1:0] col_b_next;
  logic [AWIDTH-1:0] row_c_next;

  assign k_at_last  = (k_reg == k_last_reg);
  assign j_at_last  = (j_reg == n_last_reg);
  assign i_at_last  = (i_reg == m_last_reg);
  assign any_zero   = (m_tiles == '0) || (n_tiles == '0) || (k_tiles == '0);
  assign k_next     = k_reg + CNT_ONE;
  assign row_a_next = row_a_reg + step_a_reg;
  assign col_b_next = col_b_reg + TILE_STEP;
  assign row_c_next = row_c_reg + step_c_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      m_last_reg        <= '0;
      n_last_reg        <= '0;
      k_last_reg        <= '0;
      step_a_reg        <= '0;
      step_b_reg        <= '0;
      step_c_reg        <= '0;
      base_b_reg        <= '0;
      i_reg             <= '0;
      j_reg             <= '0;
      k_reg             <= '0;
      row_a_reg         <= '0;
      col_b_reg         <= '0;
      row_c_reg         <= '0;
      addr_a_reg        <= '0;
      addr_b_reg        <= '0;
      addr_c_reg        <= '0;
      core_start_reg    <= 1'b0;
      core_pe_reset_reg <= 1'b0;
      c_commit_reg      <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      done_reg          <= 1'b0;
      core_pe_reset_reg <= 1'b0;

      if ((state_reg != S_IDLE) && abort) begin
        state_reg      <= S_IDLE;
        core_start_reg <= 1'b0;
        c_commit_reg   <= 1'b0;
        busy_reg       <= 1'b0;
        done_reg       <= 1'b0 | 1'b1;
        err_reg        <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              if (any_zero) begin
                done_reg <= 1'b1;
                err_reg  <= 1'b1;
              end else begin
                err_reg           <= 1'b0;
                m_last_reg        <= m_tiles - CNT_ONE;
                n_last_reg        <= n_tiles - CNT_ONE;
                k_last_reg        <= k_tiles - CNT_ONE;
                step_a_reg        <= row_step_a;
                step_b_reg        <= row_step_b;
                step_c_reg        <= row_step_c;
                base_b_reg        <= base_b;
                i_reg             <= '0;
                j_reg             <= '0;
                k_reg             <= '0;
                row_a_reg         <= base_a;
                col_b_reg         <= base_b;
                row_c_reg         <= base_c;
                addr_a_reg        <= base_a;
                addr_b_reg        <= base_b;
                addr_c_reg        <= base_c;
                core_pe_reset_reg <= 1'b1;
                busy_reg          <= 1'b1;
                state_reg         <= S_CLEAR;
              end
            end
          end

          S_CLEAR: begin
            core_start_reg <= 1'b1;
            c_commit_reg   <= k_at_last;
            state_reg      <= S_LAUNCH;
          end

          S_LAUNCH: begin
            if (core_done) begin
              core_start_reg <= 1'b0;
              state_reg      <= S_DRAIN;
            end
          end

          // Leaving only on a low core_done guarantees core_start never rises into a stale done.
          S_DRAIN: begin
            if (!core_done) begin
              c_commit_reg <= 1'b0;
              state_reg    <= S_ADVANCE;
            end
          end

          S_ADVANCE: begin
            if (!k_at_last) begin
              k_reg          <= k_next;
              addr_a_reg     <= addr_a_reg + TILE_STEP;
              addr_b_reg     <= addr_b_reg + step_b_reg;
              core_start_reg <= 1'b1;
              c_commit_reg   <= (k_next == k_last_reg);
              state_reg      <= S_LAUNCH;
            end else begin
              k_reg <= '0;
              if (!j_at_last) begin
                j_reg      <= j_reg + CNT_ONE;
                addr_a_reg <= row_a_reg;
                col_b_reg  <= col_b_next;
                addr_b_reg <= col_b_next;
                addr_c_reg <= addr_c_reg + TILE_STEP;
              end else begin
                j_reg      <= '0;
                i_reg      <= i_reg + CNT_ONE;
                row_a_reg  <= row_a_next;
                addr_a_reg <= row_a_next;
                col_b_reg  <= base_b_reg;
                addr_b_reg <= base_b_reg;
                row_c_reg  <= row_c_next;
                addr_c_reg <= row_c_next;
              end
              if (j_at_last && i_at_last) begin
                done_reg  <= 1'b1;
                state_reg <= S_DONE;
              end else begin
                core_pe_reset_reg <= 1'b1;
                state_reg         <= S_CLEAR;
              end
            end
          end

          S_DONE: begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end

          default: begin
            core_start_reg <= 1'b0;
            c_commit_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            state_reg      <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign core_start    = core_start_reg;
  assign core_pe_reset = core_pe_reset_reg;
  assign c_commit      = c_commit_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign core_addr_a   = addr_a_reg;
  assign core_addr_b   = addr_b_reg;
  assign core_addr_c   = addr_c_reg;
  assign tile_i        = i_reg;
  assign tile_j        = j_reg;
  assign tile_k        = k_reg;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: plays the core side by hand and
// checks addresses, handshakes, error and completion against hand-computed values.
module tb_matmul_tile_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] m_tiles, n_tiles, k_tiles;
  logic [9:0] base_a, base_b, base_c;
  logic [9:0] row_step_a, row_step_b, row_step_c;
  logic       core_start;
  logic       core_done;
  logic       core_pe_reset;
  logic [9:0] core_addr_a, core_addr_b, core_addr_c;
  logic       c_commit;
  logic [3:0] tile_i, tile_j, tile_k;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  matmul_tile_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .m_tiles(m_tiles), .n_tiles(n_tiles), .k_tiles(k_tiles),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .row_step_a(row_step_a), .row_step_b(row_step_b), .row_step_c(row_step_c),
    .core_start(core_start), .core_done(core_done), .core_pe_reset(core_pe_reset),
    .core_addr_a(core_addr_a), .core_addr_b(core_addr_b), .core_addr_c(core_addr_c),
    .c_commit(c_commit), .tile_i(tile_i), .tile_j(tile_j), .tile_k(tile_k),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] m, n, k, input logic [9:0] ba, bb, bc, sa, sb, sc);
    m_tiles = m; n_tiles = n; k_tiles = k;
    base_a = ba; base_b = bb; base_c = bc;
    row_step_a = sa; row_step_b = sb; row_step_c = sc;
  endtask

  // Pulses start for one edge and checks the sequencer entered CLEAR.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_pe_reset", 32'(core_pe_reset), 1);
    chk("start_err_clr", 32'(err), 0);
  endtask

  task automatic wait_launch(output int clr, output int ticks, output bit ok);
    clr = 0; ticks = 0; ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (core_pe_reset) clr++;
      if (core_start) begin
        ok = 1'b1;
        break;
      end
      tick();
      ticks++;
    end
  endtask

  task automatic serve(input string tag, input logic [31:0] ea, eb, ec,
                       input int ecommit, eclr, eticks, delay, hold);
    int clr, ticks;
    bit ok;
    wait_launch(clr, ticks, ok);
    chk({tag, "_launch"}, 32'(ok), 1);
    chk({tag, "_addr_a"}, 32'(core_addr_a), ea);
    chk({tag, "_addr_b"}, 32'(core_addr_b), eb);
    chk({tag, "_addr_c"}, 32'(core_addr_c), ec);
    chk({tag, "_commit"}, 32'(c_commit), 32'(ecommit));
    chk({tag, "_clears"}, 32'(clr), 32'(eclr));
    chk({tag, "_latency"}, 32'(ticks), 32'(eticks));
    repeat (delay) tick();
    core_done = 1'b1;
    tick();
    chk({tag, "_drain_start"}, 32'(core_start), 0);
    chk({tag, "_drain_commit"}, 32'(c_commit), 32'(ecommit));
    for (int h = 1; h < hold; h++) begin
      tick();
      chk({tag, "_hold_start"}, 32'(core_start), 0);
    end
    core_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int eerr);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_done_busy"}, 32'(busy), 1);
    chk({tag, "_done_err"}, 32'(err), 32'(eerr));
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_done"}, 32'(done), 0);
  endtask

  initial begin
    int clr, ticks;
    bit ok;
    reset = 1'b1; start = 1'b0; abort = 1'b0; core_done = 1'b0;
    set_cfg(4'd0, 4'd0, 4'd0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_pe_reset", 32'(core_pe_reset), 0);
    chk("rst_addr_c", 32'(core_addr_c), 0);
    reset = 1'b0;
    tick();

    // Single tile, core answers after 10 cycles.
    set_cfg(4'd1, 4'd1, 4'd1, 10'h000, 10'h010, 10'h020, 10'h0, 10'h0, 10'h0);
    do_start();
    serve("t1", 'h000, 'h010, 'h020, 1, 1, 1, 9, 1);
    wait_done("t1", 0);

    // 2x1x2 tiles: accumulation over k, clears only at k=0.
    set_cfg(4'd2, 4'd1, 4'd2, 10'h0, 10'h0, 10'h0, 10'd8, 10'd4, 10'd8);
    do_start();
    serve("t2_000", 0, 0, 0, 0, 1, 1, 2, 1);
    serve("t2_001", 4, 4, 0, 1, 0, 2, 1, 1);
    serve("t2_100", 8, 0, 8, 0, 1, 3, 3, 2);
    chk("t2_tile_i", 32'(tile_i), 1);
    serve("t2_101", 12, 4, 8, 1, 0, 2, 0, 1);
    wait_done("t2", 0);

    // Zero count: immediate done with error, no core activity.
    set_cfg(4'd1, 4'd1, 4'd0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_err", 32'(err), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_core_start", 32'(core_start), 0);
    tick();
    chk("zero_done_fall", 32'(done), 0);
    chk("zero_err_sticky", 32'(err), 1);
    chk("zero_core_start2", 32'(core_start), 0);

    // Abort during LAUNCH of tile (0,1,0), then a valid start clears err.
    set_cfg(4'd1, 4'd2, 4'd1, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_start_err_clr", 32'(err), 0);
    serve("ab_000", 0, 0, 0, 1, 1, 1, 1, 1);
    wait_launch(clr, ticks, ok);
    chk("ab_010_launch", 32'(ok), 1);
    chk("ab_010_tile_j", 32'(tile_j), 1);
    chk("ab_010_addr_b", 32'(core_addr_b), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_core_start", 32'(core_start), 0);
    chk("ab_commit", 32'(c_commit), 0);
    chk("ab_done", 32'(done), 1);
    chk("ab_err", 32'(err), 1);
    chk("ab_busy", 32'(busy), 0);
    set_cfg(4'd1, 4'd1, 4'd1, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    do_start();
    serve("ab_re", 0, 0, 0, 1, 1, 1, 0, 1);
    wait_done("ab_re", 0);

    // C address wraps modulo 2^10.
    set_cfg(4'd1, 4'd2, 4'd1, 10'h0, 10'h0, 10'h3FC, 10'h0, 10'h0, 10'd8);
    do_start();
    serve("wr_0", 0, 0, 'h3FC, 1, 1, 1, 1, 1);
    serve("wr_1", 0, 4, 'h000, 1, 1, 3, 1, 1);
    wait_done("wr", 0);

    // core_done held for 5 cycles, then reset lands mid-DRAIN.
    set_cfg(4'd1, 4'd1, 4'd2, 10'h100, 10'h0, 10'h0, 10'h0, 10'd16, 10'h0);
    do_start();
    serve("hd_0", 'h100, 0, 0, 0, 1, 1, 0, 5);
    wait_launch(clr, ticks, ok);
    chk("hd_1_launch", 32'(ok), 1);
    chk("hd_1_latency", 32'(ticks), 2);
    chk("hd_1_addr_a", 32'(core_addr_a), 'h104);
    chk("hd_1_addr_b", 32'(core_addr_b), 16);
    core_done = 1'b1;
    tick();
    chk("hd_drain_start", 32'(core_start), 0);
    chk("hd_drain_commit", 32'(c_commit), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_commit", 32'(c_commit), 0);
    chk("mid_rst_tile_k", 32'(tile_k), 0);
    chk("mid_rst_addr_a", 32'(core_addr_a), 0);
    chk("mid_rst_done", 32'(done), 0);
    core_done = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
- Parametrised tile sequencer that runs large matrix products on the existing 4x4 systolic core by iterating over TILE x TILE tiles.
- Sits between the APB register block and the systolic core.
- Takes one start with tile counts, base addresses and row steps, then performs one core operation per (i, j, k) tile triple.
- Drives per-tile A/B/C addresses, accumulator clear and C-commit, and reports completion or error.

Parameters:
- AWIDTH, 10, BRAM address width.
- TILE, 4, tile edge, equal to the core's MAT_MUL_SIZE.
- CNT_W, 4, width of the tile-count fields; maximum 2^CNT_W-1 tiles per dimension.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE.
- abort  in  1  synchronous stop request.
- m_tiles  in  CNT_W  tile rows of A and C.
- n_tiles  in  CNT_W  tile columns of B and C.
- k_tiles  in  CNT_W  reduction tiles.
- base_a / base_b / base_c  in  AWIDTH each  matrix base addresses.
- row_step_a / row_step_b / row_step_c  in  AWIDTH each  address increment per tile row.
- core_start  out  1  start_mat_mul to the core.
- core_done  in  1  done_mat_mul from the core, a level signal.
- core_pe_reset  out  1  accumulator clear pulse to the core.
- core_addr_a / core_addr_b / core_addr_c  out  AWIDTH each  tile addresses to the core.
- c_commit  out  1  core result is final and C write-back is enabled.
- tile_i / tile_j / tile_k  out  CNT_W each  current tile indices.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; counters and address registers 0.
- Inputs are captured on the cycle start is accepted; later changes are ignored until IDLE.
- Address arithmetic: incremental adders only, no multipliers; all sums wrap modulo 2^AWIDTH.
  - core_addr_a = base_a + i*row_step_a + k*TILE
  - core_addr_b = base_b + k*row_step_b + j*TILE
  - core_addr_c = base_c + i*row_step_c + j*TILE
- Loop order: i outer, j middle, k inner; i, j, k each start at 0.
- States:
  - IDLE: start=1 with any count equal to 0 -> assert done and set err=1 next cycle, stay IDLE. start=1 with all counts nonzero -> clear err, load counters and addresses, go to CLEAR.
  - CLEAR: entered only when k=0. core_pe_reset=1 for exactly one cycle, then go to LAUNCH.
  - LAUNCH: core_start=1; c_commit = (k == k_tiles-1). Held until core_done=1 is sampled, then go to DRAIN.
  - DRAIN: core_start=0, c_commit held. Wait for core_done=0, then go to ADVANCE.
  - ADVANCE (one cycle): c_commit=0.
    - k < k_tiles-1: increment k, go to LAUNCH with no clear, so the core accumulates.
    - Otherwise k=0; then j increments, or j wraps to 0 and i increments.
    - If i and j were both at their last values -> go to DONE; else go to CLEAR.
  - DONE: done=1 for one cycle, go to IDLE.
- Handshake rules:
  - core_start never rises while core_done=1.
  - Addresses and tile indices are stable from LAUNCH entry through DRAIN exit.
- Abort, in any non-IDLE state: next cycle go to IDLE with core_start, core_pe_reset and c_commit = 0; done pulses one cycle; err=1. Abort has priority over every transition on the same cycle.
- core_done=1 in IDLE, CLEAR or ADVANCE is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the core is released by its own reset.
- Latency:
  - Start to first core_start: 2 cycles (IDLE->CLEAR->LAUNCH).
  - Per-tile overhead: 2 cycles plus the core handshake, plus 1 cycle for CLEAR at k=0.
- busy = (state != IDLE). done and busy are never both high except in the DONE cycle.

Test Plan:
- m=n=k=1, base_a=0, base_b=0x10, base_c=0x20:
  - one pe_reset pulse, then core_start with addresses 0 / 0x10 / 0x20 and c_commit=1;
  - core model done after 10 cycles -> done pulse, err=0.
- m=2, n=1, k=2, row_step_a=8, row_step_b=4, row_step_c=8, bases 0:
  - A address sequence 0, 4, 8, 12;
  - B address sequence 0, 4, 0, 4;
  - C addresses 0, 0, 8, 8;
  - pe_reset only before tiles (0,0,0) and (1,0,0);
  - c_commit only on k=1.
- k_tiles=0 -> done one cycle after start, err=1, core_start never asserted.
- Abort asserted during LAUNCH of tile (0,1,0) -> next cycle core_start=0, done=1, err=1, busy=0; a following valid start clears err.
- base_c=0x3FC, row_step_c=8, n=2 (AWIDTH=10) -> C addresses 0x3FC then 0x000, wrapping.
- core_done held high for 5 cycles after the first tile -> core_start does not reassert until 1 cycle after core_done falls; reset asserted mid-DRAIN -> all outputs 0 immediately.
